ga_crossover: RTL and testbench

//  Genetic-algorithm operator block: an internal 32-bit PRNG produces two 8-bit

---
 rtl/ga_pkg.sv | 16 +
 rtl/ga_crossover_if.sv | 9 +
 rtl/rng8.sv | 22 ++
 rtl/ga_crossover.sv | 32 +++
 tb/tb_ga_crossover.sv | 103 ++++++++++
 5 files changed

// File: rtl/ga_pkg.sv
// ga_pkg: shared chromosome type, PRNG seed/shift constants and the xorshift32 step
package ga_pkg;
  localparam int WIDTH = 8;
  localparam int CUT = 4;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;
  typedef logic signed [WIDTH-1:0] chromosome_t;
  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << XS_A);
    t = t ^ (t >> XS_B);
    return t ^ (t << XS_C);
  endfunction
endpackage

// File: rtl/ga_crossover_if.sv
// ga_crossover_if: control inputs and parent/child outputs of the crossover block
interface ga_crossover_if #(parameter int WIDTH = 8);
  logic en;
  logic seed_load;
  logic [31:0] seed;
  logic signed [WIDTH-1:0] parent1, parent2, child1, child2;
  modport master(output en, seed_load, seed, input parent1, parent2, child1, child2);
  modport slave(input en, seed_load, seed, output parent1, parent2, child1, child2);
endinterface

// File: rtl/rng8.sv
// rng8: xorshift32 state register with seed load; exports two WIDTH-bit slices as parents
module rng8 import ga_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [31:0] SEED0 = DEFAULT_SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic seed_load,
  input  logic [31:0] seed,
  output logic signed [WIDTH-1:0] rnd1,
  output logic signed [WIDTH-1:0] rnd2
);
  logic [31:0] state, state_nx;
  // a zero seed would lock xorshift at zero forever, so it is replaced
  always_comb state_nx = seed_load ? (seed == '0 ? SEED0 : seed) : en ? xorshift32(state) : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= SEED0;
    else state <= state_nx;
  assign rnd1 = state[WIDTH-1:0];
  assign rnd2 = state[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/ga_crossover.sv
// ga_crossover: PRNG-fed parents and a registered single-point crossover into two children
module ga_crossover #(
  parameter int WIDTH = ga_pkg::WIDTH,
  parameter int CUT = ga_pkg::CUT,
  parameter logic [31:0] DEFAULT_SEED = ga_pkg::DEFAULT_SEED
) (
  input logic clk,
  input logic reset,
  ga_crossover_if.slave bus
);
  if (CUT <= 0 || CUT >= WIDTH || WIDTH > 16) begin : g_bad_params
    $error("ga_crossover: requires 0 < CUT < WIDTH <= 16");
  end
  rng8 #(.WIDTH(WIDTH), .SEED0(DEFAULT_SEED)) u_rng (
    .clk(clk),
    .reset(reset),
    .en(bus.en),
    .seed_load(bus.seed_load),
    .seed(bus.seed),
    .rnd1(bus.parent1),
    .rnd2(bus.parent2)
  );
  // children sample the pre-edge parents while the PRNG advances on the same edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.child1 <= '0;
      bus.child2 <= '0;
    end else if (bus.en) begin
      bus.child1 <= {bus.parent1[WIDTH-1:CUT], bus.parent2[CUT-1:0]};
      bus.child2 <= {bus.parent2[WIDTH-1:CUT], bus.parent1[CUT-1:0]};
    end
endmodule

// File: tb/tb_ga_crossover.sv
// tb_ga_crossover: table-driven directed vectors plus a scoreboarded random run for ga_crossover
module tb_ga_crossover;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  ga_crossover_if #(.WIDTH(8)) bus();
  ga_crossover dut(.clk(clk), .reset(reset), .bus(bus));
  localparam logic [31:0] FULL = 32'hFFFF_FFFF;
  typedef struct {
    logic en;
    logic sl;
    logic [31:0] seed;
    logic [31:0] exp;
    logic [31:0] mask;
    string name;
  } vec_t;
  vec_t vecs[7];
  logic [31:0] q[$];
  logic [31:0] ms;
  logic [7:0] mc1, mc2;
  int checks = 0;
  int failures = 0;
  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] a, b;
    a = s ^ {s[18:0], 13'b0};
    b = a ^ {17'b0, a[31:17]};
    return b ^ {b[26:0], 5'b0};
  endfunction
  task automatic check(input string name, input logic [31:0] exp, input logic [31:0] mask);
    logic [31:0] act;
    act = {bus.parent1, bus.parent2, bus.child1, bus.child2};
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h mask=%08h", name, act, exp, mask);
    end
  endtask
  task automatic step(input logic e, input logic sl, input logic [31:0] sd, input string name);
    @(negedge clk);
    bus.en = e;
    bus.seed_load = sl;
    bus.seed = sd;
    if (e) begin
      mc1 = {ms[7:4], ms[11:8]};
      mc2 = {ms[15:12], ms[3:0]};
    end
    ms = sl ? (sd == 0 ? 32'h1 : sd) : e ? xs(ms) : ms;
    q.push_back({ms[7:0], ms[15:8], mc1, mc2});
    @(posedge clk);
    #1;
    check(name, q.pop_front(), FULL);
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h2120_0001, FULL, "step1"};
    vecs[1] = '{1'b1, 1'b0, 32'h0, 32'h0106_2021, FULL, "step2"};
    vecs[2] = '{1'b0, 1'b1, 32'hA1EF_CDE5, 32'hE5CD_2021, FULL, "load_en0"};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 32'h0000_EDC5, 32'h0000_FFFF, "load_xover"};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h0100_EDC5, FULL, "zero_seed"};
    vecs[5] = '{1'b1, 1'b1, 32'h1234_5678, 32'h7856_0001, FULL, "load_beats_en"};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h7856_0001, FULL, "hold"};
    bus.en = 0;
    bus.seed_load = 0;
    bus.seed = 0;
    ms = 32'h1;
    mc1 = 0;
    mc2 = 0;
    #12;
    check("in_reset", 32'h0100_0000, FULL);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, "idle_model");
      check("idle_const", 32'h0100_0000, FULL);
    end
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].sl, vecs[i].seed, "vec_model");
      check(vecs[i].name, vecs[i].exp, vecs[i].mask);
    end
    for (int i = 0; i < 20000; i++) begin
      if (i == 10000) begin
        @(negedge clk);
        bus.en = 1;
        bus.seed_load = 1;
        bus.seed = 32'hDEAD_BEEF;
        #2 reset = 0;
        #1 check("async_reset", 32'h0100_0000, FULL);
        @(posedge clk);
        #1 check("reset_overrides", 32'h0100_0000, FULL);
        @(negedge clk);
        reset = 1;
        bus.en = 0;
        bus.seed_load = 0;
        ms = 32'h1;
        mc1 = 0;
        mc2 = 0;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) == 0 ? 32'h0 : $urandom(), "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
